// File: rtl/eeprom_host_seq.sv
// eeprom_host_seq: request sequencer driving the EEPROM engine WR/RD/ADDR/DATA handshake.
// Define READBACK_VERIFY_EN to read back and compare every completed write.
module eeprom_host_seq #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int WR_GAP      = 2000,
    parameter int CNT_W       = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [10:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic        rsp_mismatch,
    output logic        busy,
    output logic        WR,
    output logic        RD,
    output logic [10:0] ADDR,
    inout  wire  [7:0]  DATA,
    input  logic        ACK
);
    typedef enum logic [2:0] {
        IDLE, ISSUE_WR, ISSUE_RD, RESP, GAP
`ifdef READBACK_VERIFY_EN
        , VERIFY_RD
`endif
    } state_t;
    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAPV = CNT_W'(WR_GAP);
    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] gap_cnt;
    logic [7:0]       wdata_q;
    logic             wr_q;
    logic             mismatch_q;
    assign req_ready    = (state == IDLE) && !RESET;
    assign rsp_valid    = (state == RESP);
    assign busy         = (state != IDLE);
    assign rsp_mismatch = mismatch_q;
    assign DATA         = WR ? wdata_q : 8'hzz;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            WR          <= 1'b0;
            RD          <= 1'b0;
            ADDR        <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            timer       <= '0;
            gap_cnt     <= '0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    wr_q    <= req_wr;
                    wdata_q <= req_wdata;
                    ADDR    <= req_addr;
                    timer   <= '0;
                    WR      <= req_wr;
                    RD      <= !req_wr;
                    state   <= req_wr ? ISSUE_WR : ISSUE_RD;
                end
                ISSUE_WR: if (ACK) begin
                    WR <= 1'b0;
`ifdef READBACK_VERIFY_EN
                    gap_cnt <= GAPV;
                    if (WR_GAP == 0) begin
                        RD    <= 1'b1;
                        timer <= '0;
                        state <= VERIFY_RD;
                    end else
                        state <= GAP;
`else
                    state <= RESP;
`endif
                end else if (timer == TMAX) begin
                    WR          <= 1'b0;
                    rsp_timeout <= 1'b1;
                    rsp_rdata   <= '0;
                    state       <= RESP;
                end else
                    timer <= timer + 1'b1;
                ISSUE_RD
`ifdef READBACK_VERIFY_EN
                , VERIFY_RD
`endif
                : if (ACK) begin
                    // Capture happens on the ACK edge, while RD is still high.
                    RD        <= 1'b0;
                    rsp_rdata <= DATA;
`ifdef READBACK_VERIFY_EN
                    mismatch_q <= (state == VERIFY_RD) && (DATA != wdata_q);
`endif
                    state <= RESP;
                end else if (timer == TMAX) begin
                    RD          <= 1'b0;
                    rsp_timeout <= 1'b1;
                    rsp_rdata   <= '0;
                    state       <= RESP;
                end else
                    timer <= timer + 1'b1;
                RESP: if (rsp_ready) begin
                    rsp_rdata   <= '0;
                    rsp_timeout <= 1'b0;
                    mismatch_q  <= 1'b0;
                    gap_cnt     <= GAPV;
`ifdef READBACK_VERIFY_EN
                    state <= IDLE;
`else
                    state <= (wr_q && !rsp_timeout && WR_GAP != 0) ? GAP : IDLE;
`endif
                end
                GAP: if (gap_cnt <= 1) begin
`ifdef READBACK_VERIFY_EN
                    RD    <= 1'b1;
                    timer <= '0;
                    state <= VERIFY_RD;
`else
                    state <= IDLE;
`endif
                end else
                    gap_cnt <= gap_cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eeprom_host_seq.sv
// tb_eeprom_host_seq: directed table plus random transactions against a response-level model.
module tb_eeprom_host_seq;
    localparam int T = 24;
    localparam int G = 16;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0, ACK = 1'b0;
    logic [10:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_timeout, rsp_mismatch, busy, WR, RD;
    logic [7:0]  rsp_rdata;
    logic [10:0] ADDR;
    logic [7:0]  eng_data = 8'h96;
    wire  [7:0]  DATA;
    int          errs = 0, checks = 0;
    typedef struct {
        logic        wr;
        logic [10:0] addr;
        logic [7:0]  wdata;
        int          d;
        logic [7:0]  rdata;
        int          hold;
        logic        exp_to;
        logic [7:0]  exp_rdata;
        int          exp_cyc;
        int          exp_gap;
    } vec_t;
    vec_t tab[7];
    // The engine owns the bus whenever the sequencer is not writing.
    assign DATA = WR ? 8'hzz : eng_data;
    always #5 CLK = ~CLK;
    eeprom_host_seq #(.TIMEOUT_CYC(T), .WR_GAP(G), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout), .rsp_mismatch(rsp_mismatch), .busy(busy),
        .WR(WR), .RD(RD), .ADDR(ADDR), .DATA(DATA), .ACK(ACK)
    );
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_to    = v.d > T;
        r.exp_cyc   = r.exp_to ? T : v.d;
        r.exp_rdata = (!v.wr && !r.exp_to) ? v.rdata : 8'h00;
        r.exp_gap   = (v.wr && !r.exp_to) ? G : 0;
        return r;
    endfunction
    task automatic run(input vec_t v);
        int cyc = 0, g = 0;
        chk("ready_idle", {31'b0, req_ready}, 32'd1);
        eng_data  = v.wr ? ~v.wdata : v.rdata;
        req_valid = 1'b1;
        req_wr    = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        tick();
        req_valid = 1'b0;
        req_wr    = 1'($urandom);
        req_addr  = 11'($urandom);
        req_wdata = 8'($urandom);
        while ((WR || RD) && cyc < T + 8) begin
            cyc++;
            chk("cmd_bus", {11'b0, WR && RD, ADDR, WR, DATA},
                {11'b0, 1'b0, v.addr, v.wr, v.wr ? v.wdata : v.rdata});
            ACK = (cyc == v.d);
            tick();
        end
        ACK = 1'b0;
        chk("cmd_cycles", cyc, v.exp_cyc);
        chk("rsp_first", {20'b0, rsp_valid, req_ready, busy, rsp_timeout, rsp_rdata},
            {20'b0, 1'b1, 1'b0, 1'b1, v.exp_to, v.exp_rdata});
        chk("mismatch", {31'b0, rsp_mismatch}, 32'd0);
        chk("data_released", {24'b0, DATA}, {24'b0, eng_data});
        for (int i = 0; i < v.hold; i++) begin
            ACK = 1'($urandom);
            tick();
            chk("rsp_hold", {21'b0, rsp_valid, req_ready, rsp_timeout, rsp_rdata, WR | RD},
                {21'b0, 1'b1, 1'b0, v.exp_to, v.exp_rdata, 1'b0});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        while (busy && g < G + 8) begin
            g++;
            ACK = 1'($urandom);
            tick();
        end
        ACK = 1'b0;
        chk("gap_cycles", g, v.exp_gap);
        chk("after_rsp", {29'b0, req_ready, rsp_valid, WR | RD}, {29'b0, 1'b1, 1'b0, 1'b0});
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        vec_t v;
        tab[0] = '{1'b1, 11'h155, 8'hA5, 20,   8'h00, 2,  1'b0, 8'h00, 20, G};
        tab[1] = '{1'b0, 11'h7FF, 8'h00, 5,    8'h3C, 0,  1'b0, 8'h3C, 5,  0};
        tab[2] = '{1'b0, 11'h123, 8'h00, 1000, 8'h77, 1,  1'b1, 8'h00, T,  0};
        tab[3] = '{1'b0, 11'h0AA, 8'h00, T,    8'h81, 10, 1'b0, 8'h81, T,  0};
        tab[4] = '{1'b1, 11'h001, 8'h3E, 1000, 8'h00, 0,  1'b1, 8'h00, T,  0};
        tab[5] = '{1'b1, 11'h400, 8'hFF, 1,    8'h00, 0,  1'b0, 8'h00, 1,  G};
        tab[6] = '{1'b0, 11'h000, 8'h00, T+1,  8'hE4, 0,  1'b1, 8'h00, T,  0};
        repeat (3) tick();
        chk("reset_ready", {31'b0, req_ready}, 32'd0);
        chk("reset_outs", {9'b0, WR, RD, ADDR, rsp_valid, rsp_timeout, rsp_mismatch, busy, rsp_rdata},
            32'd0);
        chk("reset_data", {24'b0, DATA}, {24'b0, eng_data});
        RESET = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) run(tab[i]);
        eng_data  = 8'h11;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 11'h2C3;
        req_wdata = 8'hEE;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        chk("pre_reset_wr", {31'b0, WR}, 32'd1);
        RESET = 1'b1;
        #1;
        chk("midreset_outs", {17'b0, WR, RD, rsp_valid, busy, ADDR}, 32'd0);
        chk("midreset_data", {24'b0, DATA}, {24'b0, eng_data});
        tick();
        RESET = 1'b0;
        repeat (4) tick();
        chk("no_rsp_after_reset", {29'b0, rsp_valid, busy, req_ready}, 32'd1);
        run(tab[1]);
        for (int n = 0; n < 40; n++) begin
            v.wr    = 1'($urandom);
            v.addr  = 11'($urandom);
            v.wdata = 8'($urandom);
            v.rdata = 8'($urandom);
            v.d     = $urandom_range(1, T + 3);
            v.hold  = $urandom_range(0, 3);
            run(model(v));
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/eeprom_host_seq.md
Name: eeprom_host_seq

Overview:
- Host-side command sequencer sitting directly upstream of the EEPROM serial read/write engine.
- Accepts byte read/write requests on a valid/ready interface and drives the engine's WR/RD/ADDR/DATA level handshake.
- Waits for the engine's one-cycle ACK, captures read data, enforces the EEPROM internal write-cycle gap and returns one response per request.
- Guards against a hung engine with a timeout.

Parameters:
- TIMEOUT_CYC, 4096: max cycles WR/RD is held waiting for ACK before abort; range 1..65535.
- WR_GAP, 2000: idle cycles inserted after every completed write (EEPROM tWR); 0 means no gap; range 0..65535.
- CNT_W, 16: width of the timeout and gap counters; both parameters must fit in CNT_W bits.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RESET  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  11  EEPROM byte address.
- req_wdata  input  8  write byte (ignored for reads).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  8  read byte (0 for writes and timeouts).
- rsp_timeout  output  1  request aborted, ACK never seen.
- rsp_mismatch  output  1  readback compare failed (READBACK_VERIFY_EN only, else constant 0).
- busy  output  1  state != IDLE.
- WR  output  1  write command level to the engine.
- RD  output  1  read command level to the engine.
- ADDR  output  11  address to the engine.
- DATA  inout  8  parallel data bus; driven only while WR=1, else high-Z.
- ACK  input  1  engine completion pulse.

Behaviour:
- Reset (async) values:
  - WR=0, RD=0, ADDR=0, DATA released (8'hzz).
  - req_ready=0 during reset, 1 once IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_timeout=0, rsp_mismatch=0, busy=0.
  - All counters cleared; state=IDLE.
- States: IDLE, ISSUE_WR, ISSUE_RD, RESP, GAP (plus VERIFY_RD with macro).
- IDLE:
  - req_ready=1 (combinational from state).
  - On req_valid&req_ready, latch addr/wdata/wr and go to ISSUE_WR or ISSUE_RD.
  - WR/RD/ADDR/DATA are registered and change on the cycle after acceptance.
- ISSUE_WR / ISSUE_RD:
  - Hold WR or RD =1, ADDR stable, DATA=wdata (write only); the timer increments each cycle.
  - ACK=1 sampled at posedge:
    - Next cycle WR/RD=0 and DATA released.
    - Read: rsp_rdata<=DATA captured at that same edge.
    - Go to RESP.
  - Timer reaches TIMEOUT_CYC-1 with ACK=0:
    - Deassert WR/RD and release DATA.
    - rsp_timeout<=1, rsp_rdata<=0; go to RESP.
  - ACK and timeout on the same edge: ACK wins; no timeout is reported.
- RESP:
  - rsp_valid=1; rsp_* are held stable until rsp_valid&rsp_ready.
  - On handshake, go to GAP if the completed command was a write without timeout and WR_GAP>0; otherwise go to IDLE.
  - New requests are not accepted in RESP.
- GAP:
  - Counter loaded with WR_GAP on entry; decrements each cycle.
  - Exactly WR_GAP cycles in GAP, then IDLE.
- ACK while in IDLE, RESP or GAP is ignored.
- WR and RD are never both 1.
- Latency: a read with engine ACK after N cycles of WR/RD high gives rsp_valid 1 cycle after the ACK edge.
- Back-to-back: the minimum spacing is one IDLE cycle between the rsp handshake (plus gap) and the next acceptance.
- RESET mid-command: WR/RD drop immediately (async) and DATA is released. No response is produced for the aborted request.

Optional Feature:
- Macro: READBACK_VERIFY_EN.
- Defined:
  - After a write ACK, go to GAP (WR_GAP cycles, even if 0), then VERIFY_RD: issue RD to the same address with the same timeout rules.
  - On ACK, compare DATA with the latched wdata: rsp_mismatch<=(DATA!=wdata), rsp_rdata<=DATA.
  - Go to RESP, then IDLE with no second gap.
  - A timeout in either phase sets rsp_timeout=1 and rsp_mismatch=0.
- Undefined: no VERIFY_RD state; rsp_mismatch tied 0; write flow is ISSUE_WR -> RESP -> GAP -> IDLE.

Test Plan:
- Write addr 11'h155, data 8'hA5, engine ACK 20 cycles after WR rises -> WR high exactly 20 cycles, DATA=A5 throughout then Z; rsp_valid with rsp_timeout=0; busy held WR_GAP=2000 cycles after rsp handshake.
- Read addr 11'h7FF, engine drives DATA=8'h3C with ACK after 5 cycles -> RD high 5 cycles, DATA never driven by sequencer, rsp_rdata=3C.
- TIMEOUT_CYC=8, engine never ACKs -> RD high 8 cycles then 0, rsp_timeout=1, rsp_rdata=0, no GAP, req_ready back 1 cycle after handshake.
- ACK coincident with final timeout cycle -> rsp_timeout=0, data captured; rsp_ready held 0 for 10 cycles -> rsp_* stable, req_ready=0 throughout.
- RESET pulsed mid-ISSUE_WR -> WR=0 and DATA=Z within the same cycle; no rsp_valid; the next request completes normally.
- READBACK_VERIFY_EN: write 8'h5A, readback returns 8'h5B -> rsp_mismatch=1, rsp_rdata=5B; readback 8'h5A -> rsp_mismatch=0.
